registers_scoreboard: RTL
=========================

# registers_scoreboard

Parametrised general-purpose register file for the CPU datapath, replacing the fixed 32×32, two-read, always-writing register file. Adds a write enable, a configurable number of read ports, same-cycle write-to-read bypass, an optionally hardwired zero register, and a per-register busy scoreboard that the issue stage uses to detect pending writebacks. Sits between decode (read/reserve) and writeback (write).

## Interface
- DATA_WIDTH, 32, width of each register
- NUM_REGS, 32, number of architectural registers (≥2)
- READ_PORTS, 2, number of independent read ports (≥1)
- ZERO_REG, 1, 1 = register 0 reads as 0, ignores writes and is never busy
- ADDR_WIDTH, $clog2(NUM_REGS), derived, not overridden

- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- read_registers  input  READ_PORTS*ADDR_WIDTH  read addresses; port i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- results  output  READ_PORTS*DATA_WIDTH  read data; port i at [i*DATA_WIDTH +: DATA_WIDTH]
- read_busy  output  READ_PORTS  1 = addressed register has a pending write
- write_enable  input  1  commit write_data to write_register this edge
- write_register  input  ADDR_WIDTH  write address
- write_data  input  DATA_WIDTH  write data
- reserve_enable  input  1  mark reserve_register busy this edge
- reserve_register  input  ADDR_WIDTH  register to reserve

## Operation
- Storage: NUM_REGS × DATA_WIDTH registers plus NUM_REGS busy bits.
- Reset (rst=1 at rising edge): all registers ← 0, all busy bits ← 0; write and reserve that cycle ignored.
- Write: write_enable=1, rst=0 → reg[write_register] ← write_data and busy[write_register] ← 0 at edge.
- Reserve: reserve_enable=1, rst=0 → busy[reserve_register] ← 1 at edge.
- Reserve and write to same register in same cycle: data written, busy ends 1 (reserve wins; new producer issued).
- Reserve of already-busy register: stays busy (single bit, no count).
- Write to non-busy register: legal, data written, busy stays 0.
- ZERO_REG=1: writes and reserves to address 0 ignored; reads of 0 return 0, read_busy 0.
- Address ≥ NUM_REGS (non-power-of-two NUM_REGS): write/reserve ignored, read returns 0, read_busy 0.
- Reads are combinational, every port independent; any number of ports may address the same register.
- Bypass: if write_enable=1, rst=0 and read address == write_register (valid, not zero-reg), results port returns write_data and read_busy returns 0 unless reserve_enable=1 to same address this cycle (then read_busy=1, data still bypassed).
- rst=1 suppresses bypass: reads show stored contents.

## Timing
- Read latency 0 cycles (combinational from read_registers, storage and bypass inputs).
- Write/reserve visible in storage from the rising edge on which they are sampled; visible on read outputs same cycle via bypass.
- Reset values: after the reset edge all results = 0 and all read_busy = 0 for any address.
- No handshake; write and reserve accepted every cycle, no back-pressure.
- Reset mid-operation: pending busy bits and data discarded; a write asserted during the reset cycle is lost.

## Test plan
- Reset then read regs 0 and 1 on both ports → results 0, read_busy 00.
- write_enable=1, reg 0, data 0xFFFF_FFFF (ZERO_REG=1) → port 0 reads 0 same and next cycle; reg 1 same data → reads 0xFFFF_FFFF next cycle and same cycle via bypass.
- write_enable=0, reg 1, data 0xDEAD_BEEF → reg 1 unchanged at 0xFFFF_FFFF.
- Reserve reg 5 → read_busy=1 next cycle; write 0x1234_5678 to reg 5 → same cycle read_busy 0, results 0x1234_5678; next cycle busy 0.
- Same cycle reserve + write reg 7 data 0xA5A5_A5A5 → results 0xA5A5_A5A5, read_busy 1 that cycle and after.
- READ_PORTS=3, NUM_REGS=24: all three ports read reg 9 = 0xCAFE_0009 simultaneously; write/read address 30 → ignored, reads 0; reset while reg 9 busy → busy 0, data 0.

Source files
------------

// File: rtl/registers_scoreboard.sv
// registers_scoreboard
//
// General-purpose register file with write enable, a configurable number of
// combinational read ports, same-cycle write-to-read bypass, an optional
// hardwired zero register and a per-register busy bit used by issue logic to
// spot pending writebacks.
//
// Ports:
//   clk               system clock, all state changes on the rising edge
//   rst               synchronous active-high reset (clears data and busy bits)
//   read_registers    READ_PORTS packed read addresses, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   results           READ_PORTS packed read data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   read_busy         per-port busy flag of the addressed register
//   write_enable      commit write_data to write_register (also clears its busy bit)
//   write_register    write address
//   write_data        write data
//   reserve_enable    mark reserve_register busy
//   reserve_register  register to reserve
module registers_scoreboard #(
    parameter int unsigned  DATA_WIDTH = 32,
    parameter int unsigned  NUM_REGS   = 32,
    parameter int unsigned  READ_PORTS = 2,
    parameter bit           ZERO_REG   = 1'b1,
    localparam int unsigned ADDR_WIDTH = $clog2(NUM_REGS)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [READ_PORTS*ADDR_WIDTH-1:0] read_registers,
    output logic [READ_PORTS*DATA_WIDTH-1:0] results,
    output logic [READ_PORTS-1:0]            read_busy,
    input  logic                             write_enable,
    input  logic [ADDR_WIDTH-1:0]            write_register,
    input  logic [DATA_WIDTH-1:0]            write_data,
    input  logic                             reserve_enable,
    input  logic [ADDR_WIDTH-1:0]            reserve_register
);

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [NUM_REGS-1:0]   busy_q;
    logic [NUM_REGS-1:0]   busy_d;

    logic wr_valid;
    logic rsv_valid;

    // An address names real, writable storage: in range (NUM_REGS need not be a
    // power of two) and not the hardwired zero register.
    function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
        return (32'(a) < NUM_REGS) && !(ZERO_REG && (a == '0));
    endfunction

    // Reset also suppresses the bypass path, so fold it into the qualifiers.
    assign wr_valid  = write_enable && !rst && addr_ok(write_register);
    assign rsv_valid = reserve_enable && !rst && addr_ok(reserve_register);

    // Reserve is applied after the write clear so a simultaneous reserve wins.
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_valid && (write_register == ADDR_WIDTH'(i))) begin
                busy_d[i] = 1'b0;
            end
            if (rsv_valid && (reserve_register == ADDR_WIDTH'(i))) begin
                busy_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            busy_q <= busy_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_valid && (write_register == ADDR_WIDTH'(i))) begin
                    regs_q[i] <= write_data;
                end
            end
        end
    end

    // Combinational read ports. Out-of-range and zero-register reads fall through
    // to the all-zero default; an in-flight write overrides the stored value.
    always_comb begin
        logic [ADDR_WIDTH-1:0] rd_addr;
        rd_addr   = '0;
        results   = '0;
        read_busy = '0;
        for (int p = 0; p < READ_PORTS; p++) begin
            rd_addr = read_registers[p*ADDR_WIDTH +: ADDR_WIDTH];
            if (addr_ok(rd_addr)) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (rd_addr == ADDR_WIDTH'(i)) begin
                        results[p*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
                        read_busy[p]                        = busy_q[i];
                    end
                end
            end
            if (wr_valid && (rd_addr == write_register)) begin
                results[p*DATA_WIDTH +: DATA_WIDTH] = write_data;
                read_busy[p] = rsv_valid && (reserve_register == write_register);
            end
        end
    end

endmodule
